// File: rtl/uart_pkg.sv
// Shared encodings for the multi-parameter UART receiver: parity modes, FSM states,
// FIFO entry layout and the 2-of-3 vote helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int DATA_LSB = 0;
    localparam int PERR     = 8;
    localparam int FERR     = 9;
    localparam int BRK      = 10;
    localparam int ENTRY_W  = 11;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received frames; the head entry is visible
// combinationally whenever the FIFO is not empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int ENTRY_W = uart_pkg::ENTRY_W,
    parameter int FIFO_AW = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               i_wr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic               i_rd,
    output logic [ENTRY_W-1:0] o_rdata,
    output logic               o_full,
    output logic               o_empty,
    output logic [FIFO_AW:0]   o_level
);

    logic [ENTRY_W-1:0] r_mem [2**FIFO_AW];
    logic [FIFO_AW:0]   r_wr_ptr;
    logic [FIFO_AW:0]   r_rd_ptr;
    logic               w_wr_en;
    logic               w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_rdata = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    // A pop frees the head slot in the same cycle, so a write while full is still safe.
    assign w_rd_en = i_rd && !o_empty;
    assign w_wr_en = i_wr && (!o_full || w_rd_en);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_rx_mp.sv
// Runtime-configurable UART receiver (5-8 data bits, parity, 1/2 stop bits) with
// 3-sample majority voting, per-frame error flags and a buffered FWFT output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a synchronised 1->0 edge, config latched on it
// ST_START  | voting the start bit; a majority 1 is treated as a glitch
// ST_DATA   | sampling N data bits LSB-first
// ST_PARITY | sampling and checking the parity bit
// ST_STOP   | sampling 1 or 2 stop bits; frame pushed at last vote
module uart_rx_mp
    import uart_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               uart_rx,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [1:0]         cfg_data_bits,
    input  logic [1:0]         cfg_parity,
    input  logic               cfg_stop2,
    output logic [7:0]         rx_data,
    output logic               rx_perr,
    output logic               rx_ferr,
    output logic               rx_brk,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               rx_overrun,
    input  logic               clr_overrun,
    output logic               rx_busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(8);

    rx_state_t          r_state;
    logic [1:0]         r_sync;
    logic               r_hist;
    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [2:0]         r_nbits_m1;
    logic [1:0]         r_par;
    logic               r_stop2;
    logic [2:0]         r_idx;
    logic               r_s0;
    logic               r_s1;
    logic [7:0]         r_data;
    logic               r_perr;
    logic               r_ferr;
    logic               r_brk;
    logic               r_parbit;
    logic               r_brk_hold;
    logic               r_push;
    logic [ENTRY_W-1:0] r_entry;
    logic               r_overrun;

    logic               w_rx;
    logic               w_start;
    logic [DIV_W-1:0]   w_q;
    logic [DIV_W-1:0]   w_h;
    logic [DIV_W-1:0]   w_tq;
    logic               w_wrap;
    logic               w_at_tq;
    logic               w_vote;
    logic               w_par_en;
    logic               w_par_exp;
    logic               w_brk_n;
    logic               w_ferr_n;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;

    assign w_rx    = r_sync[1];
    assign w_start = r_hist && !w_rx && !r_brk_hold;

    assign w_q     = r_div >> 2;
    assign w_h     = r_div >> 1;
    assign w_tq    = w_q + w_h;
    assign w_wrap  = (r_cnt == r_div - DIV_W'(1));
    assign w_at_tq = (r_cnt == w_tq);
    assign w_vote  = maj3(r_s0, r_s1, w_rx);

    assign w_par_en  = (r_par == PAR_ODD) || (r_par == PAR_EVEN);
    assign w_par_exp = (r_par == PAR_ODD) ? ~^r_data : ^r_data;

    // Break needs an all-zero frame up to and including the first stop bit.
    assign w_brk_n  = r_brk || (!w_vote && r_idx == 3'd0 && r_data == 8'd0 && !r_parbit);
    assign w_ferr_n = r_ferr || !w_vote;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync     <= 2'b11;
            r_hist     <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], uart_rx};
            r_hist     <= w_rx;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_div      <= DIV_MIN;
            r_nbits_m1 <= 3'd7;
            r_par      <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_idx      <= 3'd0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_data     <= 8'd0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
            r_parbit   <= 1'b0;
            r_brk_hold <= 1'b0;
            r_push     <= 1'b0;
            r_entry    <= '0;
        end else begin
            r_push <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_rx) r_brk_hold <= 1'b0;
                if (w_start) begin
                    r_div      <= (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
                    r_nbits_m1 <= {1'b1, cfg_data_bits};
                    r_par      <= cfg_parity;
                    r_stop2    <= cfg_stop2;
                    r_cnt      <= '0;
                    r_idx      <= 3'd0;
                    r_data     <= 8'd0;
                    r_perr     <= 1'b0;
                    r_ferr     <= 1'b0;
                    r_brk      <= 1'b0;
                    r_parbit   <= 1'b0;
                    r_state    <= ST_START;
                end
            end else begin
                r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
                if (r_cnt == w_q) r_s0 <= w_rx;
                if (r_cnt == w_h) r_s1 <= w_rx;
                case (r_state)
                    ST_START: begin
                        if (w_at_tq && w_vote) r_state <= ST_IDLE;
                        else if (w_wrap)       r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (w_at_tq) r_data[r_idx] <= w_vote;
                        if (w_wrap) begin
                            if (r_idx == r_nbits_m1) begin
                                r_idx   <= 3'd0;
                                r_state <= w_par_en ? ST_PARITY : ST_STOP;
                            end else begin
                                r_idx <= r_idx + 3'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_at_tq) begin
                            r_parbit <= w_vote;
                            r_perr   <= (w_vote != w_par_exp);
                        end
                        if (w_wrap) r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (w_at_tq) begin
                            r_ferr <= w_ferr_n;
                            r_brk  <= w_brk_n;
                            // Completing at the last vote leaves slack for the next start edge.
                            if (r_idx == {2'b00, r_stop2}) begin
                                r_push     <= 1'b1;
                                r_entry    <= {w_brk_n, w_ferr_n, r_perr, r_data};
                                r_brk_hold <= w_brk_n;
                                r_state    <= ST_IDLE;
                            end
                        end else if (w_wrap) begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_pop = rx_ready && !w_empty;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                      r_overrun <= 1'b0;
        else if (r_push && w_full && !w_pop) r_overrun <= 1'b1;
        else if (clr_overrun)                r_overrun <= 1'b0;
    end

    uart_rx_fifo #(
        .ENTRY_W (ENTRY_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_wr      (r_push),
        .i_wdata   (r_entry),
        .i_rd      (w_pop),
        .o_rdata   (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    // Stale RAM contents stay hidden while the FIFO is empty.
    assign rx_valid   = !w_empty;
    assign rx_data    = w_empty ? 8'd0 : w_head[DATA_LSB +: 8];
    assign rx_perr    = !w_empty && w_head[PERR];
    assign rx_ferr    = !w_empty && w_head[FERR];
    assign rx_brk     = !w_empty && w_head[BRK];
    assign rx_overrun = r_overrun;
    assign rx_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_mp.sv
// Directed bench for uart_rx_mp: frames are driven bit by bit and every
// popped entry is compared with hand-computed data and flags.
module tb_uart_rx_mp;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [15:0] cfg_div = 16'd16;
    logic [1:0]  cfg_data_bits = 2'd3;
    logic [1:0]  cfg_parity = 2'd0;
    logic        cfg_stop2 = 1'b0;
    logic        rx_ready = 1'b0;
    logic        clr_overrun = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_brk, rx_valid, rx_overrun, rx_busy;
    logic [4:0]  fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_mp #(.DIV_W(16), .FIFO_AW(4)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .uart_rx       (uart_rx),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .rx_data       (rx_data),
        .rx_perr       (rx_perr),
        .rx_ferr       (rx_ferr),
        .rx_brk        (rx_brk),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_overrun    (rx_overrun),
        .clr_overrun   (clr_overrun),
        .rx_busy       (rx_busy),
        .fifo_level    (fifo_level)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int cyc);
        uart_rx = b;
        repeat (cyc) @(posedge sys_clk);
    endtask

    // par_mode: 0 none, 1 odd, 2 even; flip inverts the correct parity bit.
    task automatic send_frame(input logic [7:0] d, input int nb, input int par_mode,
                              input logic flip, input int nstop, input logic last_stop,
                              input int cyc);
        logic x;
        x = 1'b0;
        send_bit(1'b0, cyc);
        for (int i = 0; i < nb; i++) begin
            send_bit(d[i], cyc);
            x = x ^ d[i];
        end
        if (par_mode == 1) send_bit(~x ^ flip, cyc);
        if (par_mode == 2) send_bit(x ^ flip, cyc);
        for (int s = 0; s < nstop; s++) send_bit((s == nstop - 1) ? last_stop : 1'b1, cyc);
        uart_rx = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic perr,
                             input logic ferr, input logic brk);
        int k;
        k = 0;
        #1;
        while (!rx_valid && k < 400) begin
            @(posedge sys_clk); #1;
            k++;
        end
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        chk(tag, {21'd0, rx_brk, rx_ferr, rx_perr, rx_data}, {21'd0, brk, ferr, perr, d});
        rx_ready = 1'b1;
        @(posedge sys_clk); #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge sys_clk); #1;
        chk("rst_outputs", {rx_valid, rx_overrun, rx_busy, fifo_level, rx_brk, rx_ferr, rx_perr, rx_data}, 32'd0);
        sys_rst_n = 1'b1;
        repeat (5) @(posedge sys_clk); #1;

        // 8N1 0xA5: entry written at T+1, rx_valid visible at T+2
        send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1, 16);
        #1;
        chk("a5_t1_valid", {31'd0, rx_valid}, 32'd0);
        @(posedge sys_clk); #1;
        chk("a5_t2_valid", {31'd0, rx_valid}, 32'd1);
        chk("a5_level", {27'd0, fifo_level}, 32'd1);
        pop_check("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("a5_empty", {27'd0, fifo_level}, 32'd0);

        // 7E1 0x41 with wrong then correct parity
        cfg_data_bits = 2'd2; cfg_parity = 2'd2;
        send_frame(8'h41, 7, 2, 1'b1, 1, 1'b1, 16);
        pop_check("7e1_bad", 8'h41, 1'b1, 1'b0, 1'b0);
        send_frame(8'h41, 7, 2, 1'b0, 1, 1'b1, 16);
        pop_check("7e1_ok", 8'h41, 1'b0, 1'b0, 1'b0);

        // 5O1 0x15, correct odd parity
        cfg_data_bits = 2'd0; cfg_parity = 2'd1;
        send_frame(8'h15, 5, 1, 1'b0, 1, 1'b1, 16);
        pop_check("5o1", 8'h15, 1'b0, 1'b0, 1'b0);

        // 8N2 with second stop bit low
        cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b1;
        send_frame(8'h55, 8, 0, 1'b0, 2, 1'b0, 16);
        pop_check("8n2_ferr", 8'h55, 1'b0, 1'b1, 1'b0);

        // Break: line low for two 12-bit frame times
        repeat (8) @(posedge sys_clk);
        uart_rx = 1'b0;
        repeat (2 * 12 * 16) @(posedge sys_clk); #1;
        chk("brk_level_low", {27'd0, fifo_level}, 32'd1);
        uart_rx = 1'b1;
        repeat (64) @(posedge sys_clk); #1;
        chk("brk_level_high", {27'd0, fifo_level}, 32'd1);
        pop_check("brk", 8'h00, 1'b0, 1'b1, 1'b1);

        // 3-cycle glitch on idle line
        cfg_stop2 = 1'b0;
        repeat (8) @(posedge sys_clk);
        send_bit(1'b0, 3);
        uart_rx = 1'b1;
        repeat (60) @(posedge sys_clk); #1;
        chk("glitch_level", {27'd0, fifo_level}, 32'd0);
        chk("glitch_busy", {31'd0, rx_busy}, 32'd0);

        // Divisor below minimum runs at 8 cycles per bit
        cfg_div = 16'd4;
        send_frame(8'h96, 8, 0, 1'b0, 1, 1'b1, 8);
        pop_check("div_min", 8'h96, 1'b0, 1'b0, 1'b0);
        cfg_div = 16'd16;

        // Overrun: 17 frames with consumer stalled
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 8, 0, 1'b0, 1, 1'b1, 16);
            repeat (4) @(posedge sys_clk);
        end
        repeat (10) @(posedge sys_clk); #1;
        chk("ovr_level", {27'd0, fifo_level}, 32'd16);
        chk("ovr_flag", {31'd0, rx_overrun}, 32'd1);
        chk("ovr_head_stable", {24'd0, rx_data}, 32'd0);
        for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i), 8'(i), 1'b0, 1'b0, 1'b0);
        chk("drain_valid", {31'd0, rx_valid}, 32'd0);
        chk("ovr_sticky", {31'd0, rx_overrun}, 32'd1);
        clr_overrun = 1'b1;
        @(posedge sys_clk); #1;
        clr_overrun = 1'b0;
        chk("ovr_clear", {31'd0, rx_overrun}, 32'd0);

        // Reset in the middle of bit 4 with three entries queued
        send_frame(8'h11, 8, 0, 1'b0, 1, 1'b1, 16);
        send_frame(8'h22, 8, 0, 1'b0, 1, 1'b1, 16);
        send_frame(8'h33, 8, 0, 1'b0, 1, 1'b1, 16);
        repeat (4) @(posedge sys_clk);
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
        send_bit(1'b1, 8);
        #1;
        chk("pre_rst_level", {27'd0, fifo_level}, 32'd3);
        chk("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
        sys_rst_n = 1'b0;
        uart_rx = 1'b1;
        #1;
        chk("mid_rst_outputs", {rx_valid, rx_overrun, rx_busy, fifo_level, rx_brk, rx_ferr, rx_perr, rx_data}, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (20) @(posedge sys_clk); #1;
        chk("post_rst_level", {27'd0, fifo_level}, 32'd0);
        send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b1, 16);
        pop_check("post_rst_3c", 8'h3C, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
